instr_fetch_unit: RTL and testbench

- Producer side of the instruction-decode interface: owns the PC, fetches instruction words from instruction memory and presents opcode/funct/instruction fields to the control decoder.
- Consumes the decoder's flow-control outputs (Jump, JumpReg, Branch, BranchNot) plus the ALU Zero flag to compute the next PC.
- Sits between instruction memory and the decode/execute datapath of the MIPS core.

---
 rtl/instr_fetch_unit_if.sv | 37 +++
 rtl/instr_fetch_unit.sv | 97 +++++++++
 tb/tb_instr_fetch_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response plus the decode-side
// instruction fields and flow-control feedback from the core.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_o;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_ack;
  logic        Jump;
  logic        JumpReg;
  logic        Branch;
  logic        BranchNot;
  logic        Zero;
  logic [31:0] rs_data;
  logic        align_err;
  logic [31:0] instr_count;

  modport master (
    output imem_req, imem_addr, instr_o, opcode, funct, instr_valid,
           pc_o, pc_plus4_o, align_err, instr_count,
    input  imem_ready, imem_rdata, instr_ack, Jump, JumpReg, Branch,
           BranchNot, Zero, rs_data
  );

  modport slave (
    input  imem_req, imem_addr, instr_o, opcode, funct, instr_valid,
           pc_o, pc_plus4_o, align_err, instr_count,
    output imem_ready, imem_rdata, instr_ack, Jump, JumpReg, Branch,
           BranchNot, Zero, rs_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch unit: owns the PC, fetches one word at a time and
// holds it for decode until the core acknowledges, then resolves the next PC.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {ST_RST, ST_REQ, ST_HOLD} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] addr_reg;
  logic [31:0] instr_reg;
  logic [31:0] count_reg;
  logic        req_reg;
  logic        valid_reg;
  logic        align_err_reg;

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] pc_next;
  logic        branch_taken;
  logic        misaligned;

  always_comb begin
    pc_plus4     = pc_reg + 32'd4;
    branch_off   = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
    branch_taken = (bus.Branch & bus.Zero) | (bus.BranchNot & ~bus.Zero);
    misaligned   = bus.JumpReg & (bus.rs_data[1:0] != 2'b00);
    // jr beats j/jal, which beats a taken branch
    if (bus.JumpReg)
      pc_next = {bus.rs_data[31:2], 2'b00};
    else if (bus.Jump)
      pc_next = {pc_plus4[31:28], instr_reg[25:0], 2'b00};
    else if (branch_taken)
      pc_next = pc_plus4 + branch_off;
    else
      pc_next = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_RST;
      pc_reg        <= RESET_PC;
      addr_reg      <= RESET_PC;
      instr_reg     <= 32'h0;
      count_reg     <= 32'h0;
      req_reg       <= 1'b0;
      valid_reg     <= 1'b0;
      align_err_reg <= 1'b0;
    end else begin
      align_err_reg <= 1'b0;
      case (state_reg)
        ST_RST: begin
          state_reg <= ST_REQ;
          req_reg   <= 1'b1;
          addr_reg  <= pc_reg;
        end
        ST_REQ: begin
          if (bus.imem_ready) begin
            instr_reg <= bus.imem_rdata;
            valid_reg <= 1'b1;
            req_reg   <= 1'b0;
            state_reg <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.instr_ack) begin
            pc_reg        <= pc_next;
            addr_reg      <= pc_next;
            count_reg     <= count_reg + 32'd1;
            valid_reg     <= 1'b0;
            req_reg       <= 1'b1;
            align_err_reg <= misaligned;
            state_reg     <= ST_REQ;
          end
        end
        default: state_reg <= ST_RST;
      endcase
    end
  end

  assign bus.imem_req    = req_reg;
  assign bus.imem_addr   = addr_reg;
  assign bus.instr_o     = instr_reg;
  assign bus.opcode      = instr_reg[31:26];
  assign bus.funct       = instr_reg[5:0];
  assign bus.instr_valid = valid_reg;
  assign bus.pc_o        = pc_reg;
  assign bus.pc_plus4_o  = pc_plus4;
  assign bus.align_err   = align_err_reg;
  assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: fetch addresses go through a
// scoreboard queue; next-PC cases come from a vector table.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst;

  instr_fetch_unit_if bus_if();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        jump;
    logic        jumpreg;
    logic        branch;
    logic        branchnot;
    logic        zero;
    logic [31:0] rs;
    logic [31:0] exp_next;
    logic        exp_align;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          exp_count = 0;
  logic [31:0] cur_pc;
  logic [31:0] held;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ctl();
    bus_if.instr_ack = 1'b0;
    bus_if.Jump      = 1'b0;
    bus_if.JumpReg   = 1'b0;
    bus_if.Branch    = 1'b0;
    bus_if.BranchNot = 1'b0;
    bus_if.Zero      = 1'b0;
    bus_if.rs_data   = 32'h0;
  endtask

  // Answer one fetch: wait for the request, compare its address with the
  // scoreboard, optionally stall, then return data and check the HOLD view.
  task automatic serve(input logic [31:0] data, input int stall, input bit ack_in_stall);
    int          n = 0;
    logic [31:0] exp_addr;
    while (bus_if.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check32("req_seen", {31'h0, bus_if.imem_req}, 32'h1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty: got fetch %h required none", bus_if.imem_addr);
      exp_addr = 32'hDEAD_BEEF;
    end else begin
      exp_addr = exp_q.pop_front();
    end
    check32("fetch_addr", bus_if.imem_addr, exp_addr);
    for (int i = 0; i < stall; i++) begin
      bus_if.instr_ack = ack_in_stall && (i == 2);
      @(negedge clk);
      bus_if.instr_ack = 1'b0;
      check32("stall_addr", bus_if.imem_addr, exp_addr);
      check32("stall_req", {31'h0, bus_if.imem_req}, 32'h1);
      check32("stall_count", bus_if.instr_count, 32'(exp_count));
    end
    bus_if.imem_ready = 1'b1;
    bus_if.imem_rdata = data;
    @(negedge clk);
    bus_if.imem_ready = 1'b0;
    bus_if.imem_rdata = $urandom;
    check32("valid_after_ready", {31'h0, bus_if.instr_valid}, 32'h1);
    check32("instr_o", bus_if.instr_o, data);
    check32("opcode", {26'h0, bus_if.opcode}, {26'h0, data[31:26]});
    check32("funct", {26'h0, bus_if.funct}, {26'h0, data[5:0]});
    check32("req_dropped", {31'h0, bus_if.imem_req}, 32'h0);
    check32("align_err_clear", {31'h0, bus_if.align_err}, 32'h0);
    $display("fetch addr=%h instr=%h count=%0d", exp_addr, data, bus_if.instr_count);
  endtask

  task automatic ack(input logic j, input logic jr, input logic b, input logic bn,
                     input logic z, input logic [31:0] rs,
                     input logic [31:0] exp_next, input logic exp_align);
    bus_if.Jump      = j;
    bus_if.JumpReg   = jr;
    bus_if.Branch    = b;
    bus_if.BranchNot = bn;
    bus_if.Zero      = z;
    bus_if.rs_data   = rs;
    bus_if.instr_ack = 1'b1;
    exp_q.push_back(exp_next);
    exp_count++;
    @(negedge clk);
    clear_ctl();
    check32("valid_after_ack", {31'h0, bus_if.instr_valid}, 32'h0);
    check32("align_err", {31'h0, bus_if.align_err}, {31'h0, exp_align});
    check32("instr_count", bus_if.instr_count, 32'(exp_count));
    check32("pc_after_ack", bus_if.pc_o, exp_next);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0010, 32'h1000_0003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0000_0020, 1'b0};
    vecs[1] = '{32'h0000_0010, 32'h1000_0003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0000_0014, 1'b0};
    vecs[2] = '{32'h0000_0010, 32'h1400_0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0020, 1'b0};
    vecs[3] = '{32'h0000_0010, 32'h1000_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0000_0010, 1'b0};
    vecs[4] = '{32'h0040_0000, 32'h0C00_0040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0100, 1'b0};
    vecs[5] = '{32'h0000_0080, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0023, 32'h0000_0020, 1'b1};
    vecs[6] = '{32'h0000_0080, 32'h0000_0008, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0040, 1'b0};
    vecs[7] = '{32'h0000_0010, 32'h1400_0003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_0014, 1'b0};
    vecs[8] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0000, 1'b0};
    vecs[9] = '{32'h0000_0100, 32'h0800_0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h0000_0040, 1'b0};

    clear_ctl();
    bus_if.imem_ready = 1'b0;
    bus_if.imem_rdata = 32'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check32("rst_req", {31'h0, bus_if.imem_req}, 32'h0);
    check32("rst_valid", {31'h0, bus_if.instr_valid}, 32'h0);
    check32("rst_pc", bus_if.pc_o, 32'h0);
    check32("rst_count", bus_if.instr_count, 32'h0);
    check32("rst_addr", bus_if.imem_addr, 32'h0);
    check32("rst_instr", bus_if.instr_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check32("release_req", {31'h0, bus_if.imem_req}, 32'h1);
    exp_q.push_back(32'h0);

    // Sequential fetch with 1-cycle memory
    serve(32'h2008_0001, 0, 1'b0);
    ack(0, 0, 0, 0, 0, 32'h0, 32'h4, 1'b0);
    serve(32'h2009_0002, 0, 1'b0);
    ack(0, 0, 0, 0, 0, 32'h0, 32'h8, 1'b0);
    serve(32'h012A_4020, 0, 1'b0);
    ack(0, 0, 0, 0, 0, 32'h0, 32'hC, 1'b0);
    check32("seq_count3", bus_if.instr_count, 32'd3);
    serve(32'h0000_0000, 0, 1'b0);

    // Table: jr to the vector PC, fetch its instruction, resolve next PC
    for (int v = 0; v < 10; v++) begin
      ack(0, 1, 0, 0, 0, vecs[v].pc, vecs[v].pc, 1'b0);
      serve(vecs[v].instr, 0, 1'b0);
      check32("hold_pc", bus_if.pc_o, vecs[v].pc);
      check32("hold_pc_plus4", bus_if.pc_plus4_o, vecs[v].pc + 32'd4);
      ack(vecs[v].jump, vecs[v].jumpreg, vecs[v].branch, vecs[v].branchnot,
          vecs[v].zero, vecs[v].rs, vecs[v].exp_next, vecs[v].exp_align);
      serve(32'h0000_0000, 0, 1'b0);
    end
    cur_pc = vecs[9].exp_next;

    // Flow control and stray imem_ready without ack: nothing moves
    held = bus_if.instr_o;
    bus_if.Jump       = 1'b1;
    bus_if.JumpReg    = 1'b1;
    bus_if.Branch     = 1'b1;
    bus_if.Zero       = 1'b1;
    bus_if.rs_data    = 32'h0000_0200;
    bus_if.imem_ready = 1'b1;
    bus_if.imem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    clear_ctl();
    bus_if.imem_ready = 1'b0;
    check32("noack_valid", {31'h0, bus_if.instr_valid}, 32'h1);
    check32("noack_req", {31'h0, bus_if.imem_req}, 32'h0);
    check32("noack_pc", bus_if.pc_o, cur_pc);
    check32("noack_instr", bus_if.instr_o, held);
    check32("noack_count", bus_if.instr_count, 32'(exp_count));

    // Stalled memory with an ack pulse during REQ
    ack(0, 0, 0, 0, 0, 32'h0, cur_pc + 32'd4, 1'b0);
    serve(32'h1234_5678, 5, 1'b1);
    check32("stall_final_count", bus_if.instr_count, 32'(exp_count));

    // Reset while a request is outstanding; coincident ready is discarded
    ack(0, 0, 0, 0, 0, 32'h0, cur_pc + 32'd8, 1'b0);
    check32("pre_rst_addr", bus_if.imem_addr, exp_q.pop_front());
    rst = 1'b1;
    bus_if.imem_ready = 1'b1;
    bus_if.imem_rdata = 32'hAAAA_5555;
    @(negedge clk);
    bus_if.imem_ready = 1'b0;
    check32("mid_rst_req", {31'h0, bus_if.imem_req}, 32'h0);
    check32("mid_rst_valid", {31'h0, bus_if.instr_valid}, 32'h0);
    check32("mid_rst_count", bus_if.instr_count, 32'h0);
    check32("mid_rst_pc", bus_if.pc_o, 32'h0);
    check32("mid_rst_instr", bus_if.instr_o, 32'h0);
    rst = 1'b0;
    exp_count = 0;
    exp_q.push_back(32'h0);
    serve(32'h2010_0007, 0, 1'b0);
    check32("post_rst_pc", bus_if.pc_o, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
